// File: rtl/e1pkg.sv
// Shared constants for the E1 transmit path: frame geometry, TS0 words and idle fill.
package e1pkg;
  localparam int unsigned E1_NSLOT = 32;
  localparam int unsigned TSW      = $clog2(E1_NSLOT);

  localparam logic [7:0] FASW = 8'h9B;
  localparam logic [7:0] IDLE = 8'hFF;

  // Fixed-bit positions of the NFAS word; the low five bits carry Sa4..Sa8.
  localparam int unsigned NFAS_SI_BIT  = 7;
  localparam int unsigned NFAS_ONE_BIT = 6;
  localparam int unsigned NFAS_A_BIT   = 5;

  localparam logic [2:0] SP_MAX = 3'd7;

  function automatic logic [7:0] nfas_word(input logic abit, input logic [4:0] sabits);
    logic [7:0] w;
    w               = {3'b000, sabits};
    w[NFAS_SI_BIT]  = 1'b1;
    w[NFAS_ONE_BIT] = 1'b1;
    w[NFAS_A_BIT]   = abit;
    return w;
  endfunction
endpackage

// File: rtl/e1tscnt.sv
// Timeslot / frame-parity counter with request-spacing (slip) detection.
module e1tscnt
  import e1pkg::*;
(
  input  logic           clk2,
  input  logic           rst,
  input  logic           en,
  input  logic           acc,
  output logic [TSW-1:0] ts,
  output logic           fp,
  output logic           slip
);

  logic [TSW-1:0] ts_q;
  logic           fp_q;
  logic [2:0]     sp_q;
  logic           spv_q;
  logic           slip_q;

  // spv_q marks that a previous accept exists, so the first accept after
  // reset or enable never reports a slip.
  always_ff @(posedge clk2) begin
    if (rst || !en) begin
      ts_q   <= '0;
      fp_q   <= 1'b0;
      sp_q   <= '0;
      spv_q  <= 1'b0;
      slip_q <= 1'b0;
    end else begin
      slip_q <= acc && spv_q && (sp_q != SP_MAX);
      if (acc) begin
        sp_q  <= '0;
        spv_q <= 1'b1;
        if (ts_q == TSW'(E1_NSLOT - 1)) begin
          ts_q <= '0;
          fp_q <= ~fp_q;
        end else begin
          ts_q <= ts_q + 1'b1;
        end
      end else if (sp_q != SP_MAX) begin
        sp_q <= sp_q + 1'b1;
      end
    end
  end

  assign ts   = ts_q;
  assign fp   = fp_q;
  assign slip = slip_q;

endmodule

// File: rtl/e1txsched.sv
// E1 transmit timeslot scheduler: TS0 FAS/NFAS insertion, payload pop, idle fill on underrun.
module e1txsched
  import e1pkg::*;
#(
  parameter int unsigned UCNTW = 8
) (
  input  logic             clk2,
  input  logic             rst,
  input  logic             en,
  input  logic             req,
  input  logic             abit,
  input  logic [4:0]       sabits,
  input  logic [7:0]       pdat,
  input  logic             pvld,
  output logic             prd,
  output logic [7:0]       txdat,
  output logic [4:0]       tsnum,
  output logic             fodd,
  output logic             undr,
  output logic             slip,
  output logic [UCNTW-1:0] ucnt,
  input  logic             uclr
);

  logic           acc;
  logic           payload;
  logic [TSW-1:0] nts;
  logic           fp;
  logic [7:0]     byte_d;

  assign acc     = req & en & ~rst;
  assign payload = (nts != '0);
  assign prd     = acc & payload & pvld;

  e1tscnt u_tscnt (
    .clk2 (clk2),
    .rst  (rst),
    .en   (en),
    .acc  (acc),
    .ts   (nts),
    .fp   (fp),
    .slip (slip)
  );

  always_comb begin
    byte_d = IDLE;
    if (!payload) begin
      byte_d = fp ? nfas_word(abit, sabits) : FASW;
    end else if (pvld) begin
      byte_d = pdat;
    end
  end

  always_ff @(posedge clk2) begin
    if (rst || !en) begin
      txdat <= IDLE;
      tsnum <= '0;
      fodd  <= 1'b0;
      undr  <= 1'b0;
    end else begin
      undr <= acc & payload & ~pvld;
      if (acc) begin
        txdat <= byte_d;
        tsnum <= nts;
        fodd  <= fp;
      end
    end
  end

  // Counts the registered undr pulse; a clear coinciding with a pulse leaves 1.
  always_ff @(posedge clk2) begin
    if (rst) begin
      ucnt <= '0;
    end else if (uclr) begin
      ucnt <= {{(UCNTW - 1){1'b0}}, undr};
    end else if (undr && (ucnt != '1)) begin
      ucnt <= ucnt + 1'b1;
    end
  end

endmodule
